// File: rtl/clint_trap_seq_pkg.sv
// -----------------------------------------------------------------------------
// clint_trap_seq_pkg
//   Shared definitions for the CLINT trap/return sequencer:
//   - sequencer state encoding (3-bit)
//   - machine-mode CSR addresses written by the sequencer
//   - mstatus bit positions touched on trap entry / mret
//   - default mcause codes for timer interrupt and M-mode ecall
// -----------------------------------------------------------------------------
package clint_trap_seq_pkg;

  // Sequencer states. IDLE is the only state in which new work is accepted.
  typedef enum logic [2:0] {
    TS_IDLE      = 3'd0,
    TS_W_MEPC    = 3'd1,
    TS_W_MCAUSE  = 3'd2,
    TS_W_MSTATUS = 3'd3,
    TS_M_MSTATUS = 3'd4,
    TS_REDIR     = 3'd5
  } trap_state_e;

  // Machine-mode CSR addresses.
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  // mstatus field positions.
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Privilege encoding for machine mode, written into MPP.
  localparam logic [1:0] PRIV_M = 2'b11;

  // Default mcause exception/interrupt codes.
  localparam int CAUSE_M_TIMER_INT = 7;
  localparam int CAUSE_M_ECALL     = 11;

endpackage : clint_trap_seq_pkg

// File: rtl/clint_trap_seq.sv
// -----------------------------------------------------------------------------
// clint_trap_seq
//   Trap/return sequencer owning the CSR file's CLINT write port.
//   On an accepted timer interrupt or ecall it writes mepc, mcause and mstatus
//   on three consecutive cycles and then issues a one-cycle fetch redirect to
//   mtvec (direct mode). On mret it writes the restored mstatus and redirects
//   to mepc. The pipeline is stalled from the acceptance cycle until the
//   redirect cycle inclusive.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   inst_valid_i            valid instruction at the commit point
//   inst_pc_i               PC of that instruction
//   ecall_i, mret_i         instruction is ecall / mret
//   global_int_en_i         mstatus.MIE
//   mtime_int_en_i          mie.MTIE
//   mtime_int_pend_i        mip.MTIP
//   csr_mtvec_i             current mtvec
//   csr_mepc_i              current mepc
//   csr_mstatus_i           current mstatus
//   clint_csr_wen_o         CSR write enable (registered)
//   clint_csr_waddr_o       CSR write address (registered)
//   clint_csr_wdata_o       CSR write data (registered)
//   stall_o                 freeze pipeline / suppress CPU CSR writes (comb.)
//   redirect_o              one-cycle fetch redirect (registered)
//   redirect_pc_o           redirect target, valid while redirect_o=1
// -----------------------------------------------------------------------------
module clint_trap_seq
  import clint_trap_seq_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int TIMER_CAUSE = CAUSE_M_TIMER_INT,
  parameter int ECALL_CAUSE = CAUSE_M_ECALL
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inst_valid_i,
  input  logic [XLEN-1:0] inst_pc_i,
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic            global_int_en_i,
  input  logic            mtime_int_en_i,
  input  logic            mtime_int_pend_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  output logic            clint_csr_wen_o,
  output logic [11:0]     clint_csr_waddr_o,
  output logic [XLEN-1:0] clint_csr_wdata_o,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam logic [XLEN-2:0] TIMER_CODE = (XLEN-1)'(TIMER_CAUSE);
  localparam logic [XLEN-2:0] ECALL_CODE = (XLEN-1)'(ECALL_CAUSE);

  // mstatus value written on trap entry: save MIE into MPIE, disable
  // interrupts, record machine mode as the previous privilege.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    return r;
  endfunction

  // mstatus value written on mret: restore MIE from MPIE, set MPIE, and
  // keep MPP at machine mode (only M-mode is implemented).
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    return r;
  endfunction

  trap_state_e     state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] cause_reg, cause_next;
  logic [XLEN-1:0] mstat_reg, mstat_next;
  logic [XLEN-1:0] tgt_reg, tgt_next;
  logic            wen_reg, wen_next;
  logic [11:0]     waddr_reg, waddr_next;
  logic [XLEN-1:0] wdata_reg, wdata_next;
  logic            redirect_reg, redirect_next;

  logic int_take;
  logic take_trap;
  logic take_mret;
  logic accept;

  // mtvec mode bits are ignored: only direct mode is supported.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^csr_mtvec_i[1:0];

  // Interrupt has priority over ecall, ecall over mret. An interrupt is only
  // taken against a valid instruction, whose PC becomes mepc.
  always_comb begin
    int_take  = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
    take_trap = inst_valid_i & (int_take | ecall_i);
    take_mret = inst_valid_i & ~int_take & ~ecall_i & mret_i;
    // Gating with rst_n keeps stall_o low for the whole reset window.
    accept    = rst_n & (state_reg == TS_IDLE) & (take_trap | take_mret);
  end

  // Next-state and snapshot capture.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cause_next = cause_reg;
    mstat_next = mstat_reg;
    tgt_next   = tgt_reg;

    case (state_reg)
      TS_IDLE: begin
        if (accept) begin
          pc_next    = inst_pc_i;
          mstat_next = csr_mstatus_i;
          if (take_trap) begin
            state_next = TS_W_MEPC;
            cause_next = int_take ? {1'b1, TIMER_CODE} : {1'b0, ECALL_CODE};
            tgt_next   = {csr_mtvec_i[XLEN-1:2], 2'b00};
          end else begin
            state_next = TS_M_MSTATUS;
            tgt_next   = csr_mepc_i;
          end
        end
      end
      TS_W_MEPC:    state_next = TS_W_MCAUSE;
      TS_W_MCAUSE:  state_next = TS_W_MSTATUS;
      TS_W_MSTATUS: state_next = TS_REDIR;
      TS_M_MSTATUS: state_next = TS_REDIR;
      TS_REDIR:     state_next = TS_IDLE;
      default:      state_next = TS_IDLE;
    endcase
  end

  // Output registers are loaded from the state being entered, so they line
  // up with that state. Snapshot *_next values are used because the capture
  // and the first write-state transition happen on the same edge.
  always_comb begin
    wen_next      = 1'b0;
    waddr_next    = '0;
    wdata_next    = '0;
    redirect_next = 1'b0;

    case (state_next)
      TS_W_MEPC: begin
        wen_next   = 1'b1;
        waddr_next = ADDR_MEPC;
        wdata_next = pc_next;
      end
      TS_W_MCAUSE: begin
        wen_next   = 1'b1;
        waddr_next = ADDR_MCAUSE;
        wdata_next = cause_next;
      end
      TS_W_MSTATUS: begin
        wen_next   = 1'b1;
        waddr_next = ADDR_MSTATUS;
        wdata_next = trap_mstatus(mstat_next);
      end
      TS_M_MSTATUS: begin
        wen_next   = 1'b1;
        waddr_next = ADDR_MSTATUS;
        wdata_next = mret_mstatus(mstat_next);
      end
      TS_REDIR: begin
        redirect_next = 1'b1;
      end
      default: begin
        wen_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= TS_IDLE;
      pc_reg       <= '0;
      cause_reg    <= '0;
      mstat_reg    <= '0;
      tgt_reg      <= '0;
      wen_reg      <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      redirect_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      cause_reg    <= cause_next;
      mstat_reg    <= mstat_next;
      tgt_reg      <= tgt_next;
      wen_reg      <= wen_next;
      waddr_reg    <= waddr_next;
      wdata_reg    <= wdata_next;
      redirect_reg <= redirect_next;
    end
  end

  assign clint_csr_wen_o   = wen_reg;
  assign clint_csr_waddr_o = waddr_reg;
  assign clint_csr_wdata_o = wdata_reg;
  assign redirect_o        = redirect_reg;
  assign redirect_pc_o     = tgt_reg;
  assign stall_o           = (state_reg != TS_IDLE) | accept;

endmodule : clint_trap_seq

// File: tb/tb_clint_trap_seq.sv
// -----------------------------------------------------------------------------
// tb_clint_trap_seq
//   Directed and randomized transactions against a per-transaction reference
//   model that lists the expected cycle-by-cycle CSR writes and redirect.
// -----------------------------------------------------------------------------
module tb_clint_trap_seq;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid_i = 1'b0;
  logic [63:0] inst_pc_i = '0;
  logic        ecall_i = 1'b0;
  logic        mret_i = 1'b0;
  logic        global_int_en_i = 1'b0;
  logic        mtime_int_en_i = 1'b0;
  logic        mtime_int_pend_i = 1'b0;
  logic [63:0] csr_mtvec_i = '0;
  logic [63:0] csr_mepc_i = '0;
  logic [63:0] csr_mstatus_i = '0;
  logic        clint_csr_wen_o;
  logic [11:0] clint_csr_waddr_o;
  logic [63:0] clint_csr_wdata_o;
  logic        stall_o;
  logic        redirect_o;
  logic [63:0] redirect_pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          wen;
    logic [11:0] addr;
    logic [63:0] data;
    bit          redir;
    logic [63:0] rpc;
  } step_t;

  step_t exp_q[$];

  clint_trap_seq #(.XLEN(64), .TIMER_CAUSE(7), .ECALL_CAUSE(11)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .inst_valid_i      (inst_valid_i),
    .inst_pc_i         (inst_pc_i),
    .ecall_i           (ecall_i),
    .mret_i            (mret_i),
    .global_int_en_i   (global_int_en_i),
    .mtime_int_en_i    (mtime_int_en_i),
    .mtime_int_pend_i  (mtime_int_pend_i),
    .csr_mtvec_i       (csr_mtvec_i),
    .csr_mepc_i        (csr_mepc_i),
    .csr_mstatus_i     (csr_mstatus_i),
    .clint_csr_wen_o   (clint_csr_wen_o),
    .clint_csr_waddr_o (clint_csr_waddr_o),
    .clint_csr_wdata_o (clint_csr_wdata_o),
    .stall_o           (stall_o),
    .redirect_o        (redirect_o),
    .redirect_pc_o     (redirect_pc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference mstatus updates written with masks and shifts.
  function automatic logic [63:0] ref_trap_mst(input logic [63:0] m);
    return (m & ~64'h1888) | (((m >> 3) & 64'h1) << 7) | 64'h1800;
  endfunction

  function automatic logic [63:0] ref_mret_mst(input logic [63:0] m);
    return (m & ~64'h1888) | ((m >> 7) & 64'h1) << 3 | 64'h80 | 64'h1800;
  endfunction

  task automatic drive_idle();
    inst_valid_i     = 1'b0;
    ecall_i          = 1'b0;
    mret_i           = 1'b0;
    mtime_int_pend_i = 1'b0;
  endtask

  task automatic push_step(input bit w, input logic [11:0] a, input logic [63:0] d,
                           input bit r, input logic [63:0] p);
    step_t s;
    s.wen = w; s.addr = a; s.data = d; s.redir = r; s.rpc = p;
    exp_q.push_back(s);
  endtask

  // One instruction offered at the commit point, followed by the full
  // expected sequence and one idle cycle.
  task automatic do_txn(input string tag, input bit v, input logic [63:0] pc,
                        input bit ec, input bit mr, input bit gie, input bit mtie,
                        input bit mtip, input logic [63:0] mtvec,
                        input logic [63:0] mepc, input logic [63:0] mst);
    bit it;
    int n;
    step_t s;
    it = gie & mtie & mtip;
    exp_q.delete();
    if (v && (it || ec)) begin
      push_step(1, A_MEPC, pc, 0, 64'h0);
      push_step(1, A_MCAUSE, it ? 64'h8000_0000_0000_0007 : 64'd11, 0, 64'h0);
      push_step(1, A_MSTATUS, ref_trap_mst(mst), 0, 64'h0);
      push_step(0, 12'h0, 64'h0, 1, mtvec & ~64'h3);
    end else if (v && mr) begin
      push_step(1, A_MSTATUS, ref_mret_mst(mst), 0, 64'h0);
      push_step(0, 12'h0, 64'h0, 1, mepc);
    end
    n = exp_q.size();

    @(negedge clk);
    inst_valid_i = v; inst_pc_i = pc; ecall_i = ec; mret_i = mr;
    global_int_en_i = gie; mtime_int_en_i = mtie; mtime_int_pend_i = mtip;
    csr_mtvec_i = mtvec; csr_mepc_i = mepc; csr_mstatus_i = mst;
    #1;
    chk($sformatf("%s/T/stall", tag), 64'(stall_o), 64'(n != 0));
    chk($sformatf("%s/T/wen", tag), 64'(clint_csr_wen_o), 64'h0);
    chk($sformatf("%s/T/redirect", tag), 64'(redirect_o), 64'h0);

    for (int k = 0; k < n; k++) begin
      s = exp_q[k];
      @(negedge clk);
      drive_idle();
      #1;
      chk($sformatf("%s/T+%0d/wen", tag, k+1), 64'(clint_csr_wen_o), 64'(s.wen));
      chk($sformatf("%s/T+%0d/waddr", tag, k+1), 64'(clint_csr_waddr_o), 64'(s.addr));
      chk($sformatf("%s/T+%0d/wdata", tag, k+1), clint_csr_wdata_o, s.data);
      chk($sformatf("%s/T+%0d/stall", tag, k+1), 64'(stall_o), 64'h1);
      chk($sformatf("%s/T+%0d/redirect", tag, k+1), 64'(redirect_o), 64'(s.redir));
      if (s.redir)
        chk($sformatf("%s/T+%0d/redirect_pc", tag, k+1), redirect_pc_o, s.rpc);
    end

    @(negedge clk);
    drive_idle();
    #1;
    chk($sformatf("%s/after/stall", tag), 64'(stall_o), 64'h0);
    chk($sformatf("%s/after/wen", tag), 64'(clint_csr_wen_o), 64'h0);
    chk($sformatf("%s/after/redirect", tag), 64'(redirect_o), 64'h0);
    $display("txn %s: valid=%0d int=%0d ecall=%0d mret=%0d pc=%h steps=%0d",
             tag, v, it, ec, mr, pc, n);
  endtask

  initial begin
    // Reset state.
    #3;
    chk("reset/wen", 64'(clint_csr_wen_o), 64'h0);
    chk("reset/waddr", 64'(clint_csr_waddr_o), 64'h0);
    chk("reset/wdata", clint_csr_wdata_o, 64'h0);
    chk("reset/stall", 64'(stall_o), 64'h0);
    chk("reset/redirect", 64'(redirect_o), 64'h0);
    chk("reset/redirect_pc", redirect_pc_o, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Timer interrupt.
    do_txn("timer_int", 1, 64'h8000_0100, 0, 0, 1, 1, 1,
           64'h8000_0003, 64'h0, 64'h1888);
    // Ecall with interrupts disabled.
    do_txn("ecall", 1, 64'h8000_0200, 1, 0, 0, 1, 1,
           64'h8000_0003, 64'h0, 64'h1800);
    // Mret.
    do_txn("mret", 1, 64'h8000_0300, 0, 1, 0, 0, 0,
           64'h8000_0000, 64'h8000_0204, 64'h1880);
    // Interrupt and mret together: trap wins, mepc = mret PC.
    do_txn("int_mret", 1, 64'h8000_0400, 0, 1, 1, 1, 1,
           64'h8000_1001, 64'h8000_0204, 64'h1888);
    // Interrupt pending with no valid instruction, then a valid one.
    for (int i = 0; i < 3; i++)
      do_txn($sformatf("pend_novalid%0d", i), 0, 64'h8000_0500, 0, 0, 1, 1, 1,
             64'h8000_2000, 64'h0, 64'h1888);
    do_txn("pend_valid", 1, 64'h8000_0500, 0, 0, 1, 1, 1,
           64'h8000_2000, 64'h0, 64'h1888);

    // Reset asserted during W_MCAUSE aborts the sequence at once.
    @(negedge clk);
    inst_valid_i = 1; inst_pc_i = 64'h8000_0600; ecall_i = 1;
    global_int_en_i = 0; csr_mtvec_i = 64'h8000_0000; csr_mstatus_i = 64'h1888;
    @(negedge clk);
    drive_idle();
    #1;
    chk("rst_mid/W_MEPC/wen", 64'(clint_csr_wen_o), 64'h1);
    @(posedge clk);
    #2;
    chk("rst_mid/W_MCAUSE/waddr", 64'(clint_csr_waddr_o), 64'(A_MCAUSE));
    rst_n = 1'b0;
    #1;
    chk("rst_mid/wen", 64'(clint_csr_wen_o), 64'h0);
    chk("rst_mid/stall", 64'(stall_o), 64'h0);
    chk("rst_mid/redirect", 64'(redirect_o), 64'h0);
    @(posedge clk);
    #1;
    chk("rst_hold/wen", 64'(clint_csr_wen_o), 64'h0);
    chk("rst_hold/stall", 64'(stall_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn("ecall_after_rst", 1, 64'h8000_0700, 1, 0, 0, 0, 0,
           64'h8000_0044, 64'h0, 64'h0000_0000_0000_0008);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      logic [63:0] pc, mtv, mep, mst;
      bit v, ec, mr, gie, mtie, mtip;
      pc   = {$urandom, $urandom};
      mtv  = {$urandom, $urandom};
      mep  = {$urandom, $urandom};
      mst  = {$urandom, $urandom};
      v    = ($urandom_range(0, 7) != 0);
      ec   = $urandom_range(0, 1);
      mr   = $urandom_range(0, 1);
      gie  = $urandom_range(0, 1);
      mtie = ($urandom_range(0, 3) != 0);
      mtip = $urandom_range(0, 1);
      do_txn($sformatf("rand%0d", i), v, pc, ec, mr, gie, mtie, mtip, mtv, mep, mst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_clint_trap_seq
